// File: rtl/uart_core.sv
`timescale 1ns/1ps
// Purpose: free-running 8N1 UART transmitter plus independent 8N1 receiver.
// Latency: TX start bit appears on the first clock out of reset; DATA_OUT updates at the mid stop-bit sample.
// Backpressure: none; TX streams DATA_IN frames back to back, RX overwrites DATA_OUT on each good frame.
module uart_core #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX,
  input  logic [7:0] DATA_IN,
  output logic [7:0] DATA_OUT,
  output logic       TX
);

  // Bit-period counter wide enough to hold CLKS_PER_BIT-1.
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] TX_START = 2'd0;
  localparam logic [1:0] TX_DATA  = 2'd1;
  localparam logic [1:0] TX_STOP  = 2'd2;

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_WAIT  = 3'd4;

  // ---------------------------------------------------------------- TX
  logic [1:0]    tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q,   tx_cnt_d;
  logic [2:0]    tx_bit_q,   tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_q,       tx_d;
  logic          tx_last;

  // TX next state: each state drives its line level on count 0 and
  // advances on the last count, so every bit lasts exactly CLKS_PER_BIT.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    tx_last    = (tx_cnt_q == CNT_LAST);
    tx_cnt_d   = tx_last ? '0 : tx_cnt_q + CNT_ONE;
    case (tx_state_q)
      TX_START: begin
        // DATA_IN is captured only here, so mid-frame changes wait for the next frame.
        if (tx_cnt_q == '0) begin
          tx_shift_d = DATA_IN;
          tx_d       = 1'b0;
        end
        if (tx_last) begin
          tx_state_d = TX_DATA;
          tx_bit_d   = 3'd0;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_d       = tx_shift_q[0];
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
        end
        if (tx_last) begin
          tx_bit_d = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
          end
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == '0) begin
          tx_d = 1'b1;
        end
        // No idle gap: straight into the next start bit.
        if (tx_last) begin
          tx_state_d = TX_START;
        end
      end
      default: begin
        tx_state_d = TX_START;
        tx_cnt_d   = '0;
        tx_d       = 1'b1;
      end
    endcase
  end

  // TX registers; reset parks the line high with a fresh frame pending.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      tx_state_q <= TX_START;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

  assign TX = tx_q;

  // ---------------------------------------------------------------- RX
  logic rx_s1_q, rx_s2_q;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= RX;
      rx_s2_q <= rx_s1_q;
    end
  end

  logic [2:0]    rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q,   rx_cnt_d;
  logic [2:0]    rx_bit_q,   rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [7:0]    data_out_q, data_out_d;

  // RX next state: half a bit into the start bit to re-check it, then one
  // full bit period between samples so each lands mid-bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CNT_ONE;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    data_out_d = data_out_q;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_s2_q) begin
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == CNT_HALF) begin
          rx_cnt_d = '0;
          if (!rx_s2_q) begin
            rx_state_d = RX_DATA;
            rx_bit_d   = 3'd0;
          end else begin
            // Line went back high: a glitch, not a start bit.
            rx_state_d = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == CNT_LAST) begin
          rx_cnt_d = '0;
          if (rx_s2_q) begin
            data_out_d = rx_shift_q;
            rx_state_d = RX_IDLE;
          end else begin
            // Framing error: drop the byte and wait out the low line.
            rx_state_d = RX_WAIT;
          end
        end
      end
      RX_WAIT: begin
        rx_cnt_d = '0;
        if (rx_s2_q) begin
          rx_state_d = RX_IDLE;
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
        rx_cnt_d   = '0;
      end
    endcase
  end

  // RX registers; DATA_OUT only moves on a good stop bit or reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      data_out_q <= 8'h00;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      data_out_q <= data_out_d;
    end
  end

  assign DATA_OUT = data_out_q;

endmodule

// File: tb/tb_uart_core.sv
`timescale 1ns/1ps
// Bench for uart_core: TX waveform, loopback, mid-frame DATA_IN change,
// RX glitch / framing-error vectors and reset during reception.
module tb_uart_core;

  localparam int CPB = 8;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX;
  logic       TX;
  logic [7:0] DATA_IN;
  logic [7:0] DATA_OUT;

  logic loop_en;
  logic rx_bench;

  int checks = 0;
  int errors = 0;
  int first_hit;

  logic [7:0] exp_q[$];
  logic [7:0] last_seen;
  logic [7:0] prev_exp;
  logic [7:0] cur_byte;

  typedef struct {
    logic       glitch;
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[7];

  assign RX = loop_en ? TX : rx_bench;

  always #5 CLK = ~CLK;

  uart_core #(.CLKS_PER_BIT(CPB)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .RX       (RX),
    .DATA_IN  (DATA_IN),
    .DATA_OUT (DATA_OUT),
    .TX       (TX)
  );

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %02h, expected %02h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx_bench = v;
    repeat (CPB) tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int k = 0; k < 8; k++) drive_bit(d[k]);
    drive_bit(stop);
    rx_bench = 1'b1;
    repeat (2 * CPB) tick();
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return d[b-1];
  endfunction

  // Scoreboard: every change of DATA_OUT outside reset must match the next queued byte.
  always @(negedge CLK) begin
    if (RST === 1'b1 && DATA_OUT !== last_seen) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected @%0t: DATA_OUT changed to %02h, nothing expected", $time, DATA_OUT);
      end else begin
        check8("sb_byte", DATA_OUT, exp_q.pop_front());
      end
    end
    last_seen = DATA_OUT;
  end

  initial begin
    vecs[0] = '{glitch: 1'b1, data: 8'h00, stop: 1'b1, exp: 8'h00};
    vecs[1] = '{glitch: 1'b0, data: 8'hA5, stop: 1'b0, exp: 8'h00};
    vecs[2] = '{glitch: 1'b0, data: 8'h3C, stop: 1'b1, exp: 8'h3C};
    vecs[3] = '{glitch: 1'b0, data: 8'h81, stop: 1'b1, exp: 8'h81};
    vecs[4] = '{glitch: 1'b0, data: 8'h7E, stop: 1'b0, exp: 8'h81};
    vecs[5] = '{glitch: 1'b0, data: 8'hFF, stop: 1'b1, exp: 8'hFF};
    vecs[6] = '{glitch: 1'b0, data: 8'h5A, stop: 1'b1, exp: 8'h5A};

    RST      = 1'b0;
    rx_bench = 1'b1;
    loop_en  = 1'b1;
    DATA_IN  = 8'hEE;

    // Reset held for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      tick();
      check8("rst_tx", {7'd0, TX}, 8'h01);
      check8("rst_dout", DATA_OUT, 8'h00);
    end

    // TX waveform for 8'hEE with loopback into RX.
    exp_q.push_back(8'hEE);
    first_hit = -1;
    RST = 1'b1;
    for (int i = 0; i < 11 * CPB; i++) begin
      tick();
      check8("tx_wave", {7'd0, TX}, {7'd0, (i < 10 * CPB) ? frame_bit(8'hEE, i / CPB) : 1'b0});
      if (first_hit < 0 && DATA_OUT === 8'hEE) first_hit = i;
    end
    checks++;
    if (first_hit < 9 * CPB || first_hit > 11 * CPB - 1) begin
      errors++;
      $display("FAIL loop_latency: DATA_OUT=EE at cycle %0d, expected within [%0d,%0d]",
               first_hit, 9 * CPB, 11 * CPB - 1);
    end
    repeat (20 * CPB) tick();
    check8("loop_hold", DATA_OUT, 8'hEE);
    check8("loop_sb_empty", 8'(exp_q.size()), 8'h00);

    // DATA_IN changes during bit 3: current frame EE, next frame 55.
    RST = 1'b0;
    repeat (2) tick();
    DATA_IN = 8'hEE;
    exp_q.push_back(8'hEE);
    RST = 1'b1;
    for (int i = 0; i < 20 * CPB; i++) begin
      tick();
      cur_byte = (i < 10 * CPB) ? 8'hEE : 8'h55;
      check8("midchg_tx", {7'd0, TX}, {7'd0, frame_bit(cur_byte, (i / CPB) % 10)});
      if (i == 3 * CPB) DATA_IN = 8'h55;
      if (i == 10 * CPB) exp_q.push_back(8'h55);
    end
    repeat (2 * CPB) tick();
    check8("midchg_dout", DATA_OUT, 8'h55);
    check8("midchg_sb_empty", 8'(exp_q.size()), 8'h00);

    // RX vectors driven by the bench.
    RST      = 1'b0;
    loop_en  = 1'b0;
    rx_bench = 1'b1;
    repeat (3) tick();
    RST = 1'b1;
    repeat (2 * CPB) tick();
    prev_exp = 8'h00;
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].exp != prev_exp) exp_q.push_back(vecs[i].exp);
      if (vecs[i].glitch) begin
        rx_bench = 1'b0;
        repeat (CPB / 4) tick();
        rx_bench = 1'b1;
        repeat (3 * CPB) tick();
      end else begin
        send_frame(vecs[i].data, vecs[i].stop);
      end
      check8($sformatf("rx_vec%0d", i), DATA_OUT, vecs[i].exp);
      prev_exp = vecs[i].exp;
    end
    check8("rx_sb_empty", 8'(exp_q.size()), 8'h00);

    // Reset during RX bit 4, then a clean frame.
    drive_bit(1'b0);
    for (int k = 0; k < 4; k++) drive_bit(cur_byte[k] ^ 1'b1);
    rx_bench = 1'b0;
    repeat (CPB / 2) tick();
    RST = 1'b0;
    tick();
    check8("rstmid_tx", {7'd0, TX}, 8'h01);
    check8("rstmid_dout", DATA_OUT, 8'h00);
    rx_bench = 1'b1;
    tick();
    RST = 1'b1;
    repeat (2 * CPB) tick();
    check8("rstmid_hold", DATA_OUT, 8'h00);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1);
    check8("rstmid_next", DATA_OUT, 8'hC3);
    check8("rstmid_sb_empty", 8'(exp_q.size()), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
